// File: rtl/dout_display_pkg.sv
// Shared types and constants for the dout_display byte-to-7-segment converter.
// Segment constants are in active-low form; polarity is applied at the top.
package dout_display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_UPD
  } state_t;

  localparam int         ITER_COUNT  = 8;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_MINUS   = 7'h3F;
  localparam logic [3:0] DIGIT_MINUS = 4'hA;

  // Double-dabble correction step: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/dout_display_seg7_decode.sv
// Combinational digit-to-segment decoder, bit order {g,f,e,d,c,b,a}, active-low form.
module seg7_decode
  import dout_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:        seg = 7'h40;
        4'd1:        seg = 7'h79;
        4'd2:        seg = 7'h24;
        4'd3:        seg = 7'h30;
        4'd4:        seg = 7'h19;
        4'd5:        seg = 7'h12;
        4'd6:        seg = 7'h02;
        4'd7:        seg = 7'h78;
        4'd8:        seg = 7'h00;
        4'd9:        seg = 7'h10;
        DIGIT_MINUS: seg = SEG_MINUS;
        default:     seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/dout_display.sv
// Captures a data byte, converts it to BCD by double-dabble over 8 clocks and
// drives four registered 7-segment digits (sign, hundreds, tens, ones).
module dout_display
  import dout_display_pkg::*;
#(
  parameter bit SIGNED         = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dval,
  output logic       busy,
  output logic       done,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  state_t      state;
  logic [7:0]  mag;
  logic        neg;
  logic [11:0] bcd;
  logic [3:0]  iter;
  logic [6:0]  seg3, seg2, seg1, seg0;

  function automatic logic [6:0] pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? s : ~s;
  endfunction

  assign busy = (state != S_IDLE);

  // Leading-zero blanking: hundreds blank when 0, tens blank when hundreds and tens are 0.
  seg7_decode u_sign (.digit(DIGIT_MINUS), .blank(!neg),                   .seg(seg3));
  seg7_decode u_hund (.digit(bcd[11:8]),   .blank(bcd[11:8] == 4'd0),      .seg(seg2));
  seg7_decode u_tens (.digit(bcd[7:4]),    .blank(bcd[11:4] == 8'd0),      .seg(seg1));
  seg7_decode u_ones (.digit(bcd[3:0]),    .blank(1'b0),                   .seg(seg0));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      mag   <= '0;
      neg   <= 1'b0;
      bcd   <= '0;
      iter  <= '0;
      done  <= 1'b0;
      hex3  <= pol(SEG_BLANK);
      hex2  <= pol(SEG_BLANK);
      hex1  <= pol(SEG_BLANK);
      hex0  <= pol(SEG_BLANK);
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dval) begin
            // Negating 8'h80 wraps back to 8'h80, which is exactly magnitude 128.
            mag   <= (SIGNED && din[7]) ? (8'd0 - din) : din;
            neg   <= SIGNED && din[7];
            bcd   <= '0;
            iter  <= '0;
            state <= S_CONV;
          end
        end
        S_CONV: begin
          bcd  <= 12'({dd_adjust(bcd), mag[7]});
          mag  <= {mag[6:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == 4'(ITER_COUNT - 1)) state <= S_UPD;
        end
        S_UPD: begin
          hex3  <= pol(seg3);
          hex2  <= pol(seg2);
          hex1  <= pol(seg1);
          hex0  <= pol(seg0);
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dout_display.sv
// Scoreboard bench for dout_display: one signed and one unsigned instance,
// expected displays queued at stimulus time and checked on each done pulse.
module tb_dout_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_s, din_u;
  logic       dval_s, dval_u;
  logic       busy_s, done_s, busy_u, done_u;
  logic [6:0] s3, s2, s1, s0, u3, u2, u1, u0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [27:0] q_s[$];
  logic [27:0] q_u[$];
  int          done_cyc_s[$];

  localparam logic [6:0] BL = 7'h7F;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dout_display #(.SIGNED(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_dut_s (
    .clk(clk), .reset(reset), .din(din_s), .dval(dval_s),
    .busy(busy_s), .done(done_s),
    .hex3(s3), .hex2(s2), .hex1(s1), .hex0(s0)
  );

  dout_display #(.SIGNED(1'b0), .SEG_ACTIVE_LOW(1'b1)) u_dut_u (
    .clk(clk), .reset(reset), .din(din_u), .dval(dval_u),
    .busy(busy_u), .done(done_u),
    .hex3(u3), .hex2(u2), .hex1(u1), .hex0(u0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the signed instance.
  initial begin
    int  run = 0;
    logic pd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        pd  = 1'b0;
      end else begin
        if (done_s) begin
          check("done_s_single", {31'b0, pd}, 0);
          done_cyc_s.push_back(cyc);
          if (q_s.size() == 0) check("done_s_unexpected", {31'b0, done_s}, 0);
          else check("hex_s", {4'b0, s3, s2, s1, s0}, {4'b0, q_s.pop_front()});
        end
        if (busy_s) run++;
        else if (run != 0) begin
          check("busy_s_len", run, 9);
          run = 0;
        end
        pd = done_s;
      end
    end
  end

  // Monitor for the unsigned instance.
  initial begin
    int  run = 0;
    logic pd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
        pd  = 1'b0;
      end else begin
        if (done_u) begin
          check("done_u_single", {31'b0, pd}, 0);
          if (q_u.size() == 0) check("done_u_unexpected", {31'b0, done_u}, 0);
          else check("hex_u", {4'b0, u3, u2, u1, u0}, {4'b0, q_u.pop_front()});
        end
        if (busy_u) run++;
        else if (run != 0) begin
          check("busy_u_len", run, 9);
          run = 0;
        end
        pd = done_u;
      end
    end
  end

  task automatic check_blank(input string tag);
    check({tag, "_hex_s"}, {4'b0, s3, s2, s1, s0}, {4'b0, BL, BL, BL, BL});
    check({tag, "_hex_u"}, {4'b0, u3, u2, u1, u0}, {4'b0, BL, BL, BL, BL});
    check({tag, "_busy"},  {30'b0, busy_s, busy_u}, 0);
    check({tag, "_done"},  {30'b0, done_s, done_u}, 0);
  endtask

  task automatic wait_drain(input bit uns);
    int n = 0;
    while (((uns ? q_u.size() : q_s.size()) != 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    check(uns ? "drain_u" : "drain_s", uns ? q_u.size() : q_s.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic send(input bit uns, input logic [7:0] d, input logic [27:0] exp);
    @(posedge clk); #1;
    if (uns) begin din_u = d; dval_u = 1'b1; q_u.push_back(exp); end
    else     begin din_s = d; dval_s = 1'b1; q_s.push_back(exp); end
    @(posedge clk); #1;
    dval_u = 1'b0;
    dval_s = 1'b0;
    check(uns ? "busy_u_start" : "busy_s_start", {31'b0, uns ? busy_u : busy_s}, 1);
    wait_drain(uns);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad = 0;
    reset  = 1'b1;
    din_s  = '0;
    din_u  = '0;
    dval_s = 1'b0;
    dval_u = 1'b0;
    #5;
    check_blank("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    repeat (100) begin
      @(negedge clk);
      if ({s3, s2, s1, s0, u3, u2, u1, u0, busy_s, busy_u, done_s, done_u} !==
          {BL, BL, BL, BL, BL, BL, BL, BL, 4'b0}) bad++;
    end
    check("idle_hold", bad, 0);

    send(1'b0, 8'h7B, {BL,    7'h79, 7'h24, 7'h30});
    send(1'b0, 8'h80, {7'h3F, 7'h79, 7'h24, 7'h00});
    send(1'b0, 8'h05, {BL,    BL,    BL,    7'h12});
    send(1'b1, 8'hFF, {BL,    7'h24, 7'h12, 7'h12});
    send(1'b1, 8'h00, {BL,    BL,    BL,    7'h40});

    // dval held high; din changes at E3 and must not disturb the first result.
    @(posedge clk); #1;
    din_s  = 8'h2A;
    dval_s = 1'b1;
    q_s.push_back({BL, BL, 7'h19, 7'h24});
    q_s.push_back({BL, BL, BL,    7'h10});
    repeat (4) @(posedge clk);
    #1 din_s = 8'h09;
    repeat (7) @(posedge clk);
    #1 dval_s = 1'b0;
    wait_drain(1'b0);
    check("rate_10", done_cyc_s[done_cyc_s.size()-1] - done_cyc_s[done_cyc_s.size()-2], 10);

    // A dval pulse during busy is ignored.
    @(posedge clk); #1;
    din_s  = 8'h05;
    dval_s = 1'b1;
    q_s.push_back({BL, BL, BL, 7'h12});
    @(posedge clk); #1 dval_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 din_s = 8'h7B;
    dval_s = 1'b1;
    @(posedge clk); #1 dval_s = 1'b0;
    wait_drain(1'b0);
    repeat (15) @(posedge clk);
    check("ignored_pulse_hex", {4'b0, s3, s2, s1, s0}, {4'b0, BL, BL, BL, 7'h12});

    // Reset at E4 aborts the conversion.
    @(posedge clk); #1;
    din_s  = 8'h7B;
    dval_s = 1'b1;
    @(posedge clk); #1 dval_s = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_blank("abort");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    check("abort_hold_hex", {4'b0, s3, s2, s1, s0}, {4'b0, BL, BL, BL, BL});
    check("abort_idle", {31'b0, busy_s}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dout_display.md
DOUT_DISPLAY -- requirements
Module: dout_display

Interface
REQ-001 Parameter SIGNED, default 1, meaning: 1 treats din as two's complement (-128..127), 0 treats it as unsigned (0..255).
REQ-002 Parameter SEG_ACTIVE_LOW, default 1, meaning: 1 means a segment is lit by a 0 bit, 0 means lit by a 1 bit.
REQ-003 clk  input  1  system clock (50 MHz); all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 din  input  8  data byte from the SoC data bus (dout).
REQ-006 dval  input  1  data-valid qualifier for din (level-sensitive).
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  single-cycle pulse when the displays have been updated.
REQ-009 hex3  output  7  sign digit segments, bit order {g,f,e,d,c,b,a}.
REQ-010 hex2/hex1/hex0  output  7 each  hundreds/tens/ones digit segments, same bit order.

Function
REQ-011 The FSM SHALL have states IDLE, CONV and UPD, with busy = (state != IDLE).
REQ-012 In IDLE, a rising clock edge with dval=1 (the capture edge, E0) SHALL register din, load the magnitude (|din| if SIGNED and din[7]=1, else din) plus the sign flag, clear the BCD register and the iteration count, and enter CONV.
REQ-013 In CONV, each edge SHALL perform one double-dabble iteration: first add 3 to every BCD nibble >= 5, then shift left one bit, taking the next magnitude MSB.
REQ-014 The magnitude register SHALL be 8 bits and the BCD register 12 bits; -128 SHALL yield magnitude 128 without overflow.
REQ-015 After 8 iterations (edges E1..E8), the FSM SHALL enter UPD; at E9 hex0..hex3 SHALL be updated, done SHALL be high for the following cycle only, and the state SHALL return to IDLE.
REQ-016 The display latency SHALL be 9 clocks from the capture edge; busy SHALL be high for exactly 9 cycles per conversion.
REQ-017 dval and din SHALL be ignored while busy; a change of din during CONV SHALL NOT affect the result.
REQ-018 With dval held high, a new capture SHALL occur on the first IDLE edge after each completion, giving one conversion per 10 clocks.
REQ-019 hex3 SHALL show minus (segment g only) when the sign is negative, and blank otherwise; hex3 SHALL always be blank when SIGNED=0.
REQ-020 Leading zeros SHALL be blanked: hex2 blank if hundreds=0; hex1 blank if hundreds=0 and tens=0; hex0 always shown, so value 0 displays "0".
REQ-021 hex outputs SHALL be registered and SHALL hold their value between updates.
REQ-022 The digit encodings for SEG_ACTIVE_LOW=1 SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, minus=3F, blank=7F (hex). For SEG_ACTIVE_LOW=0, the bitwise inverse SHALL be used.

Reset
REQ-023 While reset=1, the state SHALL be IDLE, busy=0 and done=0, all hex outputs SHALL be blank, and the internal registers SHALL be cleared, taking effect immediately without a clock.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion: no done pulse and no display update.
REQ-025 After reset deasserts, the first capture SHALL occur on the first edge with dval=1.

Structure
REQ-026 A shared package/header SHALL hold the state encodings, ITER_COUNT=8 and the SEG_BLANK and SEG_MINUS constants (active-low form).
REQ-027 A combinational sub-module seg7_decode SHALL be used: 4-bit digit plus blank input -> 7-bit segments, instantiated four times, with polarity applied in dout_display.

Verification
REQ-028 Reset, dval=0: hex3..hex0=7F, busy=0, done=0; these values SHALL hold for 100 cycles.
REQ-029 SIGNED=1, din=8'h7B, one-cycle dval pulse: busy high for 9 cycles, done pulses once, then hex3=7F, hex2=79, hex1=24, hex0=30 ("123").
REQ-030 SIGNED=1, din=8'h80: hex3=3F, hex2=79, hex1=24, hex0=00 ("-128"); din=8'h05 gives hex3..hex1=7F, hex0=12.
REQ-031 SIGNED=0, din=8'hFF: hex3=7F, hex2=24, hex1=12, hex0=12 ("255"); din=8'h00 gives only hex0=40.
REQ-032 dval held high with din switched to 8'h09 at E3: first result unchanged, second conversion captured 10 clocks after the first capture shows hex0=10; a dval pulse during busy is ignored.
REQ-033 Reset asserted at E4 of a conversion: all hex outputs read 7F at once, busy=0, and no done pulse follows.
